// File: rtl/wb_pkg.sv
// Shared writeback definitions: default geometry, the sequencer state encoding
// (also consumed by the hazard unit) and width helpers.
package wb_pkg;

    localparam int WB_DW             = 32;
    localparam int WB_AW             = 5;
    localparam int WB_LANES          = 8;
    localparam int WB_LANES_PER_BEAT = 2;

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_BURST = 1'b1
    } wb_state_e;

    // Width of a counter/index able to hold 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int wb_nbeats(input int lanes, input int lanes_per_beat);
        return lanes / lanes_per_beat;
    endfunction

endpackage

// File: rtl/wb_vec_sequencer.sv
// Writeback controller behind MEM/WB: registered scalar RF write, and vector
// results serialised into fixed-latency beats for the vector RF write port.
module wb_vec_sequencer
    import wb_pkg::*;
#(
    parameter int DW             = WB_DW,
    parameter int AW             = WB_AW,
    parameter int LANES          = WB_LANES,
    parameter int LANES_PER_BEAT = WB_LANES_PER_BEAT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_regwrite,
    input  logic                           in_memtoreg,
    input  logic [DW-1:0]                  in_alu_result,
    input  logic [DW-1:0]                  in_read_data,
    input  logic [AW-1:0]                  in_waddr,
    input  logic                           in_vregwrite,
    input  logic [LANES*DW-1:0]            in_vdata,
    input  logic [LANES-1:0]               in_vmask,
    input  logic                           flush,
    output logic                           srf_we,
    output logic [AW-1:0]                  srf_waddr,
    output logic [DW-1:0]                  srf_wdata,
    output logic                           vrf_we,
    output logic [AW-1:0]                  vrf_waddr,
    output logic [clog2_min1(LANES)-1:0]   vrf_lane,
    output logic [LANES_PER_BEAT-1:0]      vrf_wmask,
    output logic [LANES_PER_BEAT*DW-1:0]   vrf_wdata,
    output logic                           busy
);

    localparam int NBEATS = wb_nbeats(LANES, LANES_PER_BEAT);
    localparam int CW     = clog2_min1(NBEATS);
    localparam int LW     = clog2_min1(LANES);
    localparam int BW     = LANES_PER_BEAT * DW;
    localparam int LPB_SH = $clog2(LANES_PER_BEAT);
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

    wb_state_e              r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_alive;
    logic                   r_srf_we;
    logic [AW-1:0]          r_srf_waddr;
    logic [DW-1:0]          r_srf_wdata;
    logic [LANES*DW-1:0]    r_vdata;
    logic [LANES-1:0]       r_vmask;
    logic [AW-1:0]          r_vaddr;

    logic                   w_last;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_vaccept;
    logic                   w_swrite;
    logic                   w_busy;
    logic [BW-1:0]          w_beat_data [NBEATS];
    logic [LANES_PER_BEAT-1:0] w_beat_mask [NBEATS];

    // r_alive keeps in_ready low during reset and for the release edge itself.
    assign w_last    = (r_state == WB_BURST) && (r_cnt == LAST_BEAT);
    assign w_ready   = r_alive & ((r_state == WB_IDLE) | w_last);
    assign w_accept  = in_valid & w_ready;
    assign w_vaccept = w_accept & in_vregwrite & ~flush;
    assign w_swrite  = w_accept & in_regwrite & (in_waddr != '0);
    assign w_busy    = (r_state == WB_BURST);

    for (genvar g = 0; g < NBEATS; g++) begin : g_beat
        assign w_beat_data[g] = r_vdata[g*BW +: BW];
        assign w_beat_mask[g] = r_vmask[g*LANES_PER_BEAT +: LANES_PER_BEAT];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= WB_IDLE;
            r_cnt       <= '0;
            r_alive     <= 1'b0;
            r_srf_we    <= 1'b0;
            r_srf_waddr <= '0;
            r_srf_wdata <= '0;
        end else begin
            r_alive  <= 1'b1;
            r_srf_we <= w_swrite;
            if (w_swrite) begin
                r_srf_waddr <= in_waddr;
                r_srf_wdata <= in_memtoreg ? in_read_data : in_alu_result;
            end

            case (r_state)
                WB_IDLE: begin
                    if (w_vaccept) begin
                        r_state <= WB_BURST;
                        r_cnt   <= '0;
                    end
                end
                WB_BURST: begin
                    if (flush) begin
                        r_state <= WB_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == LAST_BEAT) begin
                        // Chain straight into the next instruction when one is accepted.
                        r_cnt <= '0;
                        if (!w_vaccept) begin
                            r_state <= WB_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= WB_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // NOTE: the burst buffer is pure datapath and is not reset; every use of
    // it is gated by the BURST state, which reset does clear.
    always_ff @(posedge clk) begin
        if (w_vaccept) begin
            r_vdata <= in_vdata;
            r_vmask <= in_vmask;
            r_vaddr <= in_waddr;
        end
    end

    // NOTE: every output gets a default first so this block cannot infer latches.
    always_comb begin
        vrf_we    = 1'b0;
        vrf_waddr = '0;
        vrf_lane  = '0;
        vrf_wmask = '0;
        vrf_wdata = '0;
        if (w_busy) begin
            vrf_wmask = w_beat_mask[r_cnt];
            vrf_wdata = w_beat_data[r_cnt];
            vrf_we    = |w_beat_mask[r_cnt];
            vrf_waddr = r_vaddr;
            vrf_lane  = LW'(LW'(r_cnt) << LPB_SH);
        end
    end

    assign in_ready  = w_ready;
    assign busy      = w_busy;
    assign srf_we    = r_srf_we;
    assign srf_waddr = r_srf_waddr;
    assign srf_wdata = r_srf_wdata;

endmodule
